systolic_feeder_2x2: RTL and testbench

Sequencing front-end for the 2x2 output-stationary systolic array. Holds one 2x2 A and one 2x2 B operand matrix loaded over a simple write port, clears the array, streams rows of A and columns of B into the array edges with the diagonal skew the array requires, then latches the four accumulated results. Sits directly upstream of the array, driving its operand, clear and activation inputs, and also consumes its c00..c11 outputs.

---
 rtl/systolic_feeder_2x2_if.sv | 33 +++
 rtl/systolic_feeder_2x2.sv | 151 +++++++++++++++
 tb/tb_systolic_feeder_2x2.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_2x2_if.sv
// Host-side bus of the 2x2 systolic feeder: operand write port, start/ReLU
// request, status flags and the four latched results.
`default_nettype none

interface systolic_feeder_2x2_if #(
    parameter int WIDTH = 8
);
    logic                          load_en;
    logic                          load_sel;
    logic [1:0]                    load_addr;
    logic signed [WIDTH-1:0]       load_data;
    logic                          start;
    logic                          relu_en;
    logic                          busy;
    logic                          done;
    logic                          result_valid;
    logic signed [2*WIDTH-1:0]     r00;
    logic signed [2*WIDTH-1:0]     r01;
    logic signed [2*WIDTH-1:0]     r10;
    logic signed [2*WIDTH-1:0]     r11;

    modport master (
        output load_en, load_sel, load_addr, load_data, start, relu_en,
        input  busy, done, result_valid, r00, r01, r10, r11
    );

    modport slave (
        input  load_en, load_sel, load_addr, load_data, start, relu_en,
        output busy, done, result_valid, r00, r01, r10, r11
    );
endinterface

`default_nettype wire

// File: rtl/systolic_feeder_2x2.sv
// Sequencer for a 2x2 output-stationary systolic array: stores A/B, clears the
// array, feeds skewed rows/columns over five steps, then latches c00..c11.
`default_nettype none

module systolic_feeder_2x2 #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    systolic_feeder_2x2_if.slave      host,
    output logic signed [WIDTH-1:0]   a_data0,
    output logic signed [WIDTH-1:0]   a_data1,
    output logic signed [WIDTH-1:0]   b_data0,
    output logic signed [WIDTH-1:0]   b_data1,
    output logic                      clear,
    output logic                      activation,
    input  logic signed [2*WIDTH-1:0] c00,
    input  logic signed [2*WIDTH-1:0] c01,
    input  logic signed [2*WIDTH-1:0] c10,
    input  logic signed [2*WIDTH-1:0] c11
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_FEED  = 2'd2
    } state_t;

    localparam logic [2:0] LAST_STEP = 3'd4;

    state_t                    state;
    state_t                    state_next;
    logic [2:0]                k;
    logic signed [WIDTH-1:0]   a_mem [4];
    logic signed [WIDTH-1:0]   b_mem [4];
    logic signed [2*WIDTH-1:0] res00, res01, res10, res11;
    logic                      done_r;
    logic                      valid_r;
    logic                      start_acc;
    logic                      capture;

    assign start_acc = (state == S_IDLE) && host.start;
    assign capture   = (state == S_FEED) && (k == LAST_STEP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (host.start) state_next = S_CLEAR;
            S_CLEAR: state_next = S_FEED;
            S_FEED:  if (k == LAST_STEP) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k <= 3'd0;
        end else if (state == S_FEED && k != LAST_STEP) begin
            k <= k + 3'd1;
        end else begin
            k <= 3'd0;
        end
    end

    // Operands are writable only in IDLE so they stay frozen for the whole run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else if (state == S_IDLE && host.load_en) begin
            if (host.load_sel) begin
                b_mem[host.load_addr] <= host.load_data;
            end else begin
                a_mem[host.load_addr] <= host.load_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res00      <= '0;
            res01      <= '0;
            res10      <= '0;
            res11      <= '0;
            done_r     <= 1'b0;
            valid_r    <= 1'b0;
            activation <= 1'b0;
        end else begin
            done_r <= capture;
            if (start_acc) begin
                valid_r    <= 1'b0;
                activation <= host.relu_en;
            end
            if (capture) begin
                res00   <= c00;
                res01   <= c01;
                res10   <= c10;
                res11   <= c11;
                valid_r <= 1'b1;
            end
        end
    end

    // Diagonal skew: row/column 1 trails row/column 0 by one step.
    always_comb begin
        a_data0 = '0;
        a_data1 = '0;
        b_data0 = '0;
        b_data1 = '0;
        clear   = (state == S_CLEAR);
        if (state == S_FEED) begin
            case (k)
                3'd0: begin
                    a_data0 = a_mem[0];
                    b_data0 = b_mem[0];
                end
                3'd1: begin
                    a_data0 = a_mem[1];
                    a_data1 = a_mem[2];
                    b_data0 = b_mem[2];
                    b_data1 = b_mem[1];
                end
                3'd2: begin
                    a_data1 = a_mem[3];
                    b_data1 = b_mem[3];
                end
                default: ;
            endcase
        end
    end

    assign host.busy         = (state != S_IDLE);
    assign host.done         = done_r;
    assign host.result_valid = valid_r;
    assign host.r00          = res00;
    assign host.r01          = res01;
    assign host.r10          = res10;
    assign host.r11          = res11;

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder_2x2.sv
// Bench for systolic_feeder_2x2 with a behavioural 2x2 array attached and a
// matrix-product reference model.
`default_nettype none

module tb_systolic_feeder_2x2;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    systolic_feeder_2x2_if #(.WIDTH(W)) host();
    logic signed [W-1:0]   a_data0, a_data1, b_data0, b_data1;
    logic                  clear, activation;
    logic signed [2*W-1:0] c00, c01, c10, c11;

    systolic_feeder_2x2 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .host(host),
        .a_data0(a_data0), .a_data1(a_data1), .b_data0(b_data0), .b_data1(b_data1),
        .clear(clear), .activation(activation),
        .c00(c00), .c01(c01), .c10(c10), .c11(c11)
    );

    // Behavioural output-stationary array driven by the feeder.
    logic signed [2*W-1:0] acc00 = '0, acc01 = '0, acc10 = '0, acc11 = '0;
    logic signed [W-1:0]   pa00 = '0, pa10 = '0, pb00 = '0, pb01 = '0;
    always @(posedge clk) begin
        if (clear) begin
            acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
            pa00 <= '0; pa10 <= '0; pb00 <= '0; pb01 <= '0;
        end else begin
            acc00 <= acc00 + a_data0 * b_data0;
            acc01 <= acc01 + pa00 * b_data1;
            acc10 <= acc10 + a_data1 * pb00;
            acc11 <= acc11 + pa10 * pb01;
            pa00 <= a_data0; pa10 <= a_data1; pb00 <= b_data0; pb01 <= b_data1;
        end
    end
    assign c00 = (activation && acc00[2*W-1]) ? '0 : acc00;
    assign c01 = (activation && acc01[2*W-1]) ? '0 : acc01;
    assign c10 = (activation && acc10[2*W-1]) ? '0 : acc10;
    assign c11 = (activation && acc11[2*W-1]) ? '0 : acc11;

    int checks = 0;
    int errors = 0;
    int ma[4];
    int mb[4];

    function automatic logic [15:0] ref_c(int i, int j, bit relu);
        int s;
        logic [15:0] w;
        s = ma[i*2] * mb[j] + ma[i*2+1] * mb[2+j];
        w = s[15:0];
        if (relu && w[15]) w = '0;
        return w;
    endfunction

    function automatic logic [15:0] rget(int idx);
        case (idx)
            0:       return host.r00;
            1:       return host.r01;
            2:       return host.r10;
            default: return host.r11;
        endcase
    endfunction

    task automatic load_all();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            host.load_en   = 1'b1;
            host.load_sel  = (i >= 4);
            host.load_addr = i[1:0];
            host.load_data = (i < 4) ? W'(ma[i]) : W'(mb[i-4]);
        end
        @(negedge clk);
        host.load_en = 1'b0;
    endtask

    task automatic rand_mats();
        for (int i = 0; i < 4; i++) begin
            ma[i] = int'($urandom_range(0, 255)) - 128;
            mb[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic do_mult(input bit relu, output int lat, output int busy_c,
                           output int done_c, output int act_c);
        @(negedge clk);
        host.start   = 1'b1;
        host.relu_en = relu;
        @(posedge clk); #1;
        host.start = 1'b0;
        lat = 0; busy_c = 0; done_c = 0; act_c = 0;
        for (int n = 0; n < 20; n++) begin
            if (host.busy) busy_c++;
            if (host.busy && activation) act_c++;
            if (host.done) done_c++;
            if (host.result_valid) break;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_results(input string tag, input bit relu);
        for (int idx = 0; idx < 4; idx++) begin
            checks++;
            if (rget(idx) !== ref_c(idx / 2, idx % 2, relu)) begin
                errors++;
                $display("FAIL %s r%0d%0d got %h expected %h", tag, idx / 2, idx % 2,
                         rget(idx), ref_c(idx / 2, idx % 2, relu));
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({host.busy, host.done, host.result_valid, clear, activation} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b expected 00000",
                     {host.busy, host.done, host.result_valid, clear, activation});
        end
        checks++;
        if ({a_data0, a_data1, b_data0, b_data1} !== 32'h0) begin
            errors++;
            $display("FAIL reset_operands got %h expected 0", {a_data0, a_data1, b_data0, b_data1});
        end
        checks++;
        if ({host.r00, host.r01, host.r10, host.r11} !== 64'h0) begin
            errors++;
            $display("FAIL reset_results got %h expected 0", {host.r00, host.r01, host.r10, host.r11});
        end
    endtask

    task automatic test_basic();
        int lat, bc, dc, ac;
        ma = '{1, 2, 3, 4};
        mb = '{5, 6, 7, 8};
        load_all();
        do_mult(1'b0, lat, bc, dc, ac);
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL basic_latency got %0d expected 6", lat); end
        checks++;
        if (bc !== 6) begin errors++; $display("FAIL basic_busy_cycles got %0d expected 6", bc); end
        check_results("basic", 1'b0);
        checks++;
        if (host.r11 !== 16'd50) begin errors++; $display("FAIL basic_r11 got %0d expected 50", host.r11); end
        @(posedge clk); #1;
        if (host.done) dc++;
        checks++;
        if (dc !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d expected 1", dc); end
    endtask

    task automatic test_relu();
        int lat, bc, dc, ac;
        ma = '{-1, 2, 3, -4};
        mb = '{1, 0, 0, 1};
        load_all();
        do_mult(1'b1, lat, bc, dc, ac);
        check_results("relu_on", 1'b1);
        checks++;
        if (ac !== 6) begin errors++; $display("FAIL relu_activation_cycles got %0d expected 6", ac); end
        do_mult(1'b0, lat, bc, dc, ac);
        check_results("relu_off", 1'b0);
        checks++;
        if ({host.r00, host.r11} !== {16'hFFFF, 16'hFFFC}) begin
            errors++;
            $display("FAIL relu_off_diag got %h expected fffffffc", {host.r00, host.r11});
        end
    endtask

    task automatic test_overflow();
        int lat, bc, dc, ac;
        ma = '{-128, -128, -128, -128};
        mb = '{-128, -128, -128, -128};
        load_all();
        do_mult(1'b0, lat, bc, dc, ac);
        check_results("overflow", 1'b0);
        checks++;
        if (host.r01 !== 16'h8000) begin errors++; $display("FAIL overflow_wrap got %h expected 8000", host.r01); end
    endtask

    task automatic test_protocol();
        int lat, bc, dc, ac, n, extra_busy;
        ma = '{1, 2, 3, 4};
        mb = '{5, 6, 7, 8};
        load_all();
        @(negedge clk);
        host.start = 1'b1; host.relu_en = 1'b0;
        @(negedge clk);
        host.start = 1'b0;
        @(negedge clk);
        host.start = 1'b1;
        host.load_en = 1'b1; host.load_sel = 1'b0; host.load_addr = 2'd0; host.load_data = 8'sd9;
        @(negedge clk);
        host.start = 1'b0; host.load_en = 1'b0;
        n = 0;
        while (!host.result_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (!host.result_valid) begin errors++; $display("FAIL protocol_timeout got 0 expected 1"); end
        check_results("protocol", 1'b0);
        extra_busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (host.busy || !host.result_valid) extra_busy++;
        end
        checks++;
        if (extra_busy !== 0) begin errors++; $display("FAIL protocol_no_queue got %0d expected 0", extra_busy); end
        do_mult(1'b0, lat, bc, dc, ac);
        check_results("protocol_old_a", 1'b0);
    endtask

    task automatic test_reset_mid();
        int lat, bc, dc, ac, rv_seen;
        @(negedge clk);
        host.start = 1'b1; host.relu_en = 1'b1;
        @(posedge clk); #1;
        host.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({host.busy, host.done, host.result_valid, clear, activation, a_data0, a_data1,
             b_data0, b_data1, host.r00, host.r01, host.r10, host.r11} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got busy=%b rv=%b act=%b a0=%h r00=%h expected all 0",
                     host.busy, host.result_valid, activation, a_data0, host.r00);
        end
        rv_seen = 0;
        repeat (2) begin @(posedge clk); #1; if (host.result_valid) rv_seen++; end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (host.result_valid || host.busy) rv_seen++;
        end
        checks++;
        if (rv_seen !== 0) begin errors++; $display("FAIL midreset_no_capture got %0d expected 0", rv_seen); end
        rand_mats();
        load_all();
        do_mult(1'b0, lat, bc, dc, ac);
        check_results("midreset_rerun", 1'b0);
    endtask

    task automatic test_skew();
        int ea0[5], ea1[5], eb0[5], eb1[5];
        logic [31:0] exp_v;
        ea0 = '{1, 2, 0, 0, 0};
        ea1 = '{0, 3, 4, 0, 0};
        eb0 = '{5, 7, 0, 0, 0};
        eb1 = '{0, 6, 8, 0, 0};
        ma = '{1, 2, 3, 4};
        mb = '{5, 6, 7, 8};
        load_all();
        @(negedge clk);
        host.start = 1'b1; host.relu_en = 1'b0;
        @(posedge clk); #1;
        host.start = 1'b0;
        checks++;
        if ({clear, a_data0, a_data1, b_data0, b_data1} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL skew_clear got %b/%h expected 1/0", clear, {a_data0, a_data1, b_data0, b_data1});
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            exp_v = {W'(ea0[k]), W'(ea1[k]), W'(eb0[k]), W'(eb1[k])};
            checks++;
            if ({clear, a_data0, a_data1, b_data0, b_data1} !== {1'b0, exp_v}) begin
                errors++;
                $display("FAIL skew_k%0d got %b/%h expected 0/%h", k, clear,
                         {a_data0, a_data1, b_data0, b_data1}, exp_v);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (host.result_valid !== 1'b1) begin errors++; $display("FAIL skew_capture got %b expected 1", host.result_valid); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, dc, ac;
        bit relu;
        for (int it = 0; it < 8; it++) begin
            rand_mats();
            load_all();
            for (int rep = 0; rep < 2; rep++) begin
                relu = 1'($urandom_range(0, 1));
                do_mult(relu, lat, bc, dc, ac);
                checks++;
                if (lat !== 6 || dc !== 1) begin
                    errors++;
                    $display("FAIL b2b_timing it%0d got lat=%0d done=%0d expected 6/1", it, lat, dc);
                end
                check_results("b2b", relu);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        host.load_en = 1'b0; host.load_sel = 1'b0; host.load_addr = 2'd0;
        host.load_data = '0; host.start = 1'b0; host.relu_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        test_basic();
        test_relu();
        test_overflow();
        test_protocol();
        test_reset_mid();
        test_skew();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
